exception_module: RTL and testbench
===================================

Name: exception_module

Overview:
- CP0 exception/interrupt controller for the 5-stage MIPS pipeline.
- Consumes Status/Cause read back from the ID-stage register file, plus per-instruction exception flags arriving at MEM.
- Prioritises exceptions, takes them precisely at MEM, and drives the CP0 write interface of the register file (we, interrupt_enable, Exception_code, EXL, epc, BADADDR, Branch_delay).
- Issues the pipeline flush and PC redirect, handles ERET, and owns the Count/Compare timer interrupt.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt
TIMER_DIV, 2, clk cycles per Count increment

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Status_data  in  32  CP0 Status from register file (bit0 IE, bit1 EXL, bits15:8 IM)
cause_data  in  32  CP0 Cause from register file (bits9:8 software IP)
hardware_interruption  in  6  external interrupt lines, level-sensitive
compare_data  in  32  current CP0 Compare value
compare_we  in  1  Compare written this cycle (clears timer interrupt)
mem_valid  in  1  MEM holds a real, non-bubble instruction
pc_M  in  32  PC of the MEM instruction
in_delay_slot_M  in  1  MEM instruction is in a branch delay slot
fetch_adel_M, ri_M, ov_M, syscall_M, break_M, load_adel_M, store_ades_M  in  1 each  exception flags carried with the MEM instruction
data_addr_M  in  32  faulting data address for load/store
eret_M  in  1  MEM instruction is ERET
we  out  32  one-hot CP0 write enables by register number: [8] BadVAddr, [12] Status, [13] Cause, [14] EPC
interrupt_enable  out  8  pending IP field written to Cause[15:8]
Exception_code  out  5  ExcCode written to Cause[6:2]
EXL  out  1  EXL value written to Status[1]
epc  out  32  EPC write value
BADADDR  out  32  BadVAddr write value
Branch_delay  out  1  Cause.BD write value
flush  out  1  clear IF/ID/EX/MEM pipeline registers
redirect  out  1  force the PC
redirect_pc  out  32  PC target when redirect=1

Behaviour:
- Reset: all outputs 0 (except interrupt_enable as below); state RUN; Count=0; timer_irq=0.
- interrupt_enable every cycle = {hardware_interruption[5] | timer_irq, hardware_interruption[4:0], cause_data[9:8]}. we[13] is asserted every cycle so IP bits track continuously.
- Timer:
  - Count increments once every TIMER_DIV cycles and wraps at 2^32.
  - timer_irq sets when Count==compare_data and compare_data!=0.
  - timer_irq clears on compare_we; compare_we wins over a simultaneous match.
- Interrupt pending: Status_data[0] & ~Status_data[1] & |(interrupt_enable & Status_data[15:8]).
- Decision at MEM, evaluated only when mem_valid=1 and state=RUN. Priority: interrupt (0x00) > fetch_adel (0x04) > ri (0x0A) > ov (0x0C) > syscall (0x08) > break (0x09) > load_adel (0x04) > store_ades (0x05) > eret.
- Take cycle is combinational in the same cycle:
  - flush=1, redirect=1, redirect_pc=EXC_VECTOR.
  - Exception_code set per the priority list; EXL=1; we[12]=1.
  - epc = in_delay_slot_M ? pc_M-4 : pc_M; Branch_delay=in_delay_slot_M.
  - we[14] is asserted only if Status_data[1]==0; a nested exception leaves EPC untouched.
  - BADADDR=pc_M with we[8] for fetch_adel; data_addr_M with we[8] for load/store faults.
- ERET with no higher exception: flush=1, redirect=1, redirect_pc=EPC register value. The EPC value arrives via epc-readback; use the Status/EPC value captured on take, held internally. EXL=0, we[12]=1.
- State machine: RUN -> FLUSH on take or ERET. FLUSH lasts exactly 1 cycle: flush=1 again, no new decisions, so a redirected-fetch bubble cannot trigger. Then FLUSH -> RUN.
- mem_valid=0: no exception or ERET is taken, but the timer and IP keep updating.
- Reset during FLUSH: returns to RUN immediately, all outputs cleared.

Test Plan:
- Reset, then drive ov_M=1 with pc_M=0x80001000, mem_valid=1, Status=0 -> same cycle flush=1, redirect_pc=0xBFC00380, Exception_code=0x0C, epc=0x80001000, we[14]=we[12]=1; next cycle flush=1, no we[14].
- syscall_M and load_adel_M together, in_delay_slot_M=1, pc_M=0x80002004 -> Exception_code=0x08, epc=0x80002000, Branch_delay=1, we[8]=0.
- Status=0x0000_8001, compare_data=10 -> timer_irq rises when Count reaches 10 (~20 cycles); next valid MEM instruction takes code 0x00 with interrupt_enable[7]=1. Pulse compare_we -> timer_irq=0.
- Status.EXL=1, fetch_adel_M at pc_M=0x80000003 -> code 0x04, BADADDR=0x80000003, we[8]=1, we[14]=0.
- ERET after a prior take at 0x80001000 -> redirect_pc=0x80001000, EXL=0, we[12]=1; an ERET with mem_valid=0 is ignored.
- Assert rst in the FLUSH cycle -> next cycle flush=0, redirect=0, Count=0.

Source files
------------

// File: rtl/exception_module.sv
// ---------------------------------------------------------------------------
// exception_module
//
// CP0 exception / interrupt controller for the 5-stage MIPS pipeline.
// Exceptions are taken precisely at the MEM stage. The MEM instruction's
// exception flags are prioritised against pending interrupts. The block then
// drives the CP0 write port of the register file and requests a pipeline
// flush plus a PC redirect. It also owns the Count/Compare timer interrupt
// and handles ERET.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   Status_data, cause_data  CP0 Status / Cause read back from the register file
//   hardware_interruption    six level-sensitive external interrupt lines
//   compare_data/compare_we  current Compare value / Compare written this cycle
//   mem_valid, pc_M,         MEM-stage instruction: valid, PC,
//   in_delay_slot_M          and whether it sits in a branch delay slot
//   *_M exception flags      faults carried with the MEM instruction
//   data_addr_M              faulting data address of a load/store
//   eret_M                   MEM instruction is ERET
//   we                       one-hot CP0 write enables by register number
//   interrupt_enable         pending IP field, written to Cause[15:8]
//   Exception_code, EXL,     CP0 write data: ExcCode, Status.EXL,
//   epc, BADADDR,            EPC, BadVAddr,
//   Branch_delay             and Cause.BD
//   flush, redirect,         pipeline flush and PC redirect
//   redirect_pc              PC target used when redirect=1
// ---------------------------------------------------------------------------
module exception_module #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned TIMER_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Status_data,
    input  logic [31:0] cause_data,
    input  logic [5:0]  hardware_interruption,
    input  logic [31:0] compare_data,
    input  logic        compare_we,
    input  logic        mem_valid,
    input  logic [31:0] pc_M,
    input  logic        in_delay_slot_M,
    input  logic        fetch_adel_M,
    input  logic        ri_M,
    input  logic        ov_M,
    input  logic        syscall_M,
    input  logic        break_M,
    input  logic        load_adel_M,
    input  logic        store_ades_M,
    input  logic [31:0] data_addr_M,
    input  logic        eret_M,
    output logic [31:0] we,
    output logic [7:0]  interrupt_enable,
    output logic [4:0]  Exception_code,
    output logic        EXL,
    output logic [31:0] epc,
    output logic [31:0] BADADDR,
    output logic        Branch_delay,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    // CP0 register numbers used on the one-hot write-enable bus
    localparam int unsigned REG_BADVADDR = 8;
    localparam int unsigned REG_STATUS   = 12;
    localparam int unsigned REG_CAUSE    = 13;
    localparam int unsigned REG_EPC      = 14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Last value of the prescaler before Count advances
    localparam logic [31:0] DIV_LAST = 32'(TIMER_DIV - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [31:0] div_cnt_r;
    logic [31:0] count_r;
    logic        timer_irq_r;
    logic [31:0] epc_r;

    logic [7:0]  ip_s;
    logic        int_pending_s;
    logic        decide_s;
    logic        exc_take_s;
    logic        eret_take_s;
    logic [4:0]  exc_code_s;
    logic        bad_we_s;
    logic [31:0] bad_addr_s;
    logic [31:0] epc_val_s;
    logic        timer_match_s;

    // Status/Cause fields this block does not look at
    logic        unused_bits_s;
    assign unused_bits_s = ^{Status_data[31:16], Status_data[7:2],
                             cause_data[31:10], cause_data[7:0]};

    // Pending-interrupt vector: the timer interrupt shares line 5 with hardware.
    assign ip_s = {hardware_interruption[5] | timer_irq_r,
                   hardware_interruption[4:0],
                   cause_data[9:8]};

    // An interrupt is serviceable only with IE=1, EXL=0 and an unmasked IP bit.
    assign int_pending_s = Status_data[0] & ~Status_data[1] &
                           (|(ip_s & Status_data[15:8]));

    assign timer_match_s = (count_r == compare_data) && (compare_data != 32'h0);

    // The EPC of a delay-slot instruction points back at its branch.
    assign epc_val_s = in_delay_slot_M ? (pc_M - 32'd4) : pc_M;

    // Decisions are made only for a real instruction while not draining a flush.
    assign decide_s = mem_valid & (state_r == ST_RUN) & ~rst;

    // Prescaler, Count and the Compare-match interrupt latch
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r   <= 32'h0;
            count_r     <= 32'h0;
            timer_irq_r <= 1'b0;
        end else begin
            if (div_cnt_r >= DIV_LAST) begin
                div_cnt_r <= 32'h0;
                count_r   <= count_r + 32'd1;
            end else begin
                div_cnt_r <= div_cnt_r + 32'd1;
            end
            // A Compare write acknowledges the interrupt and beats a same-cycle match.
            if (compare_we) begin
                timer_irq_r <= 1'b0;
            end else if (timer_match_s) begin
                timer_irq_r <= 1'b1;
            end else begin
                timer_irq_r <= timer_irq_r;
            end
        end
    end

    // Exception priority encoder for the MEM instruction
    always_comb begin
        exc_take_s  = 1'b0;
        eret_take_s = 1'b0;
        exc_code_s  = EXC_INT;
        bad_we_s    = 1'b0;
        bad_addr_s  = 32'h0;
        if (decide_s) begin
            exc_take_s = 1'b1;
            if (int_pending_s) begin
                exc_code_s = EXC_INT;
            end else if (fetch_adel_M) begin
                exc_code_s = EXC_ADEL;
                bad_we_s   = 1'b1;
                bad_addr_s = pc_M;
            end else if (ri_M) begin
                exc_code_s = EXC_RI;
            end else if (ov_M) begin
                exc_code_s = EXC_OV;
            end else if (syscall_M) begin
                exc_code_s = EXC_SYS;
            end else if (break_M) begin
                exc_code_s = EXC_BP;
            end else if (load_adel_M) begin
                exc_code_s = EXC_ADEL;
                bad_we_s   = 1'b1;
                bad_addr_s = data_addr_M;
            end else if (store_ades_M) begin
                exc_code_s = EXC_ADES;
                bad_we_s   = 1'b1;
                bad_addr_s = data_addr_M;
            end else begin
                // Nothing to take; an ERET is honoured only in this case.
                exc_take_s  = 1'b0;
                eret_take_s = eret_M;
            end
        end else begin
            exc_take_s  = 1'b0;
            eret_take_s = 1'b0;
        end
    end

    // Internal copy of EPC used as the ERET return target
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_r <= 32'h0;
        end else if (exc_take_s && !Status_data[1]) begin
            epc_r <= epc_val_s;
        end else begin
            epc_r <= epc_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic: every take or ERET is followed by one flush cycle
    always_comb begin
        next_state_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (exc_take_s || eret_take_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FLUSH: next_state_s = ST_RUN;
            default:  next_state_s = ST_RUN;
        endcase
    end

    // FSM output logic: CP0 write port, flush and redirect
    always_comb begin
        we               = 32'h0;
        interrupt_enable = ip_s;
        Exception_code   = 5'h0;
        EXL              = 1'b0;
        epc              = 32'h0;
        BADADDR          = 32'h0;
        Branch_delay     = 1'b0;
        flush            = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = 32'h0;
        if (rst) begin
            // Everything except the IP field stays quiet while in reset.
            we = 32'h0;
        end else begin
            // Cause.IP is rewritten every cycle so it tracks the interrupt lines.
            we[REG_CAUSE] = 1'b1;
            case (state_r)
                ST_RUN: begin
                    if (exc_take_s) begin
                        flush          = 1'b1;
                        redirect       = 1'b1;
                        redirect_pc    = EXC_VECTOR;
                        Exception_code = exc_code_s;
                        EXL            = 1'b1;
                        we[REG_STATUS] = 1'b1;
                        epc            = epc_val_s;
                        Branch_delay   = in_delay_slot_M;
                        // Nested exception (EXL already set) must keep the original EPC.
                        we[REG_EPC]    = ~Status_data[1];
                        we[REG_BADVADDR] = bad_we_s;
                        BADADDR        = bad_addr_s;
                    end else if (eret_take_s) begin
                        flush          = 1'b1;
                        redirect       = 1'b1;
                        redirect_pc    = epc_r;
                        EXL            = 1'b0;
                        we[REG_STATUS] = 1'b1;
                    end else begin
                        flush = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Second flush cycle squashes the bubble behind the redirect.
                    flush = 1'b1;
                end
                default: begin
                    flush = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_module.sv
module tb_exception_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Status_data;
    logic [31:0] cause_data;
    logic [5:0]  hardware_interruption;
    logic [31:0] compare_data;
    logic        compare_we;
    logic        mem_valid;
    logic [31:0] pc_M;
    logic        in_delay_slot_M;
    logic        fetch_adel_M, ri_M, ov_M, syscall_M, break_M, load_adel_M, store_ades_M;
    logic [31:0] data_addr_M;
    logic        eret_M;
    logic [31:0] we;
    logic [7:0]  interrupt_enable;
    logic [4:0]  Exception_code;
    logic        EXL;
    logic [31:0] epc;
    logic [31:0] BADADDR;
    logic        Branch_delay;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exception_module dut (
        .clk(clk), .rst(rst),
        .Status_data(Status_data), .cause_data(cause_data),
        .hardware_interruption(hardware_interruption),
        .compare_data(compare_data), .compare_we(compare_we),
        .mem_valid(mem_valid), .pc_M(pc_M), .in_delay_slot_M(in_delay_slot_M),
        .fetch_adel_M(fetch_adel_M), .ri_M(ri_M), .ov_M(ov_M), .syscall_M(syscall_M),
        .break_M(break_M), .load_adel_M(load_adel_M), .store_ades_M(store_ades_M),
        .data_addr_M(data_addr_M), .eret_M(eret_M),
        .we(we), .interrupt_enable(interrupt_enable), .Exception_code(Exception_code),
        .EXL(EXL), .epc(epc), .BADADDR(BADADDR), .Branch_delay(Branch_delay),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs;
        mem_valid = 1'b0; in_delay_slot_M = 1'b0; pc_M = 32'h0; data_addr_M = 32'h0;
        {fetch_adel_M, ri_M, ov_M, syscall_M, break_M, load_adel_M, store_ades_M} = 7'b0;
        eret_M = 1'b0; compare_we = 1'b0; hardware_interruption = 6'h0; cause_data = 32'h0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // flags = {fetch_adel, ri, ov, syscall, break, load_adel, store_ades}
    task automatic prio_vec(input logic [6:0] flags, input logic [4:0] exp_code,
                            input logic [31:0] exp_we, input logic [31:0] exp_bad);
        next_cycle;
        clear_inputs;
        mem_valid = 1'b1; pc_M = 32'h8000_3000; data_addr_M = 32'h1234_5678;
        {fetch_adel_M, ri_M, ov_M, syscall_M, break_M, load_adel_M, store_ades_M} = flags;
        @(negedge clk);
        check_value("prio_code", {27'h0, Exception_code}, {27'h0, exp_code});
        check_value("prio_we", we, exp_we);
        check_value("prio_badaddr", BADADDR, exp_bad);
        next_cycle;
        clear_inputs;
        @(negedge clk);
        check_value("prio_flush2", {31'h0, flush}, 32'h1);
    endtask

    initial begin
        clear_inputs;
        Status_data  = 32'h0;
        compare_data = 32'h0;
        rst          = 1'b1;

        // Reset state
        @(negedge clk);
        check_value("rst_flush", {31'h0, flush}, 32'h0);
        check_value("rst_redirect", {31'h0, redirect}, 32'h0);
        check_value("rst_we", we, 32'h0);
        next_cycle;
        rst = 1'b0;
        @(negedge clk);
        check_value("idle_we", we, 32'h0000_2000);
        check_value("idle_flush", {31'h0, flush}, 32'h0);

        // IP field assembly
        next_cycle;
        hardware_interruption = 6'b10_0001; cause_data = 32'h0000_0300;
        @(negedge clk);
        check_value("ip_field", {24'h0, interrupt_enable}, 32'h87);
        check_value("ip_no_take", {31'h0, flush}, 32'h0);

        // Overflow take
        next_cycle;
        clear_inputs;
        mem_valid = 1'b1; ov_M = 1'b1; pc_M = 32'h8000_1000;
        @(negedge clk);
        check_value("ov_flush", {31'h0, flush}, 32'h1);
        check_value("ov_redirect", {31'h0, redirect}, 32'h1);
        check_value("ov_redirect_pc", redirect_pc, 32'hBFC0_0380);
        check_value("ov_code", {27'h0, Exception_code}, 32'h0C);
        check_value("ov_epc", epc, 32'h8000_1000);
        check_value("ov_we", we, 32'h0000_7000);
        check_value("ov_exl", {31'h0, EXL}, 32'h1);
        // FLUSH cycle: flags still present but must be ignored
        next_cycle;
        @(negedge clk);
        check_value("flush2_flush", {31'h0, flush}, 32'h1);
        check_value("flush2_redirect", {31'h0, redirect}, 32'h0);
        check_value("flush2_we", we, 32'h0000_2000);
        next_cycle;
        clear_inputs;
        @(negedge clk);
        check_value("run_again_flush", {31'h0, flush}, 32'h0);

        // ERET with mem_valid=0 is ignored
        next_cycle;
        eret_M = 1'b1; Status_data = 32'h0000_0002;
        @(negedge clk);
        check_value("eret_bubble_flush", {31'h0, flush}, 32'h0);
        check_value("eret_bubble_redirect", {31'h0, redirect}, 32'h0);
        // Real ERET returns to the captured EPC
        next_cycle;
        mem_valid = 1'b1;
        @(negedge clk);
        check_value("eret_redirect_pc", redirect_pc, 32'h8000_1000);
        check_value("eret_redirect", {31'h0, redirect}, 32'h1);
        check_value("eret_exl", {31'h0, EXL}, 32'h0);
        check_value("eret_we", we, 32'h0000_3000);
        next_cycle;
        clear_inputs; Status_data = 32'h0;
        @(negedge clk);
        check_value("eret_flush2", {31'h0, flush}, 32'h1);

        // Syscall beats load_adel in a delay slot
        next_cycle;
        mem_valid = 1'b1; syscall_M = 1'b1; load_adel_M = 1'b1;
        in_delay_slot_M = 1'b1; pc_M = 32'h8000_2004; data_addr_M = 32'hDEAD_0001;
        @(negedge clk);
        check_value("sys_code", {27'h0, Exception_code}, 32'h08);
        check_value("sys_epc", epc, 32'h8000_2000);
        check_value("sys_bd", {31'h0, Branch_delay}, 32'h1);
        check_value("sys_we", we, 32'h0000_7000);
        next_cycle;
        clear_inputs;

        // Nested fetch address error: BadVAddr written, EPC kept
        next_cycle;
        Status_data = 32'h0000_0002;
        mem_valid = 1'b1; fetch_adel_M = 1'b1; pc_M = 32'h8000_0003;
        @(negedge clk);
        check_value("nest_code", {27'h0, Exception_code}, 32'h04);
        check_value("nest_badaddr", BADADDR, 32'h8000_0003);
        check_value("nest_we", we, 32'h0000_3100);
        next_cycle;
        clear_inputs; Status_data = 32'h0;

        // Priority table
        prio_vec(7'b0110000, 5'h0A, 32'h0000_7000, 32'h0);
        prio_vec(7'b0001100, 5'h08, 32'h0000_7000, 32'h0);
        prio_vec(7'b0000110, 5'h09, 32'h0000_7000, 32'h0);
        prio_vec(7'b0000011, 5'h04, 32'h0000_7100, 32'h1234_5678);
        prio_vec(7'b0000001, 5'h05, 32'h0000_7100, 32'h1234_5678);

        // Reset asserted during the FLUSH cycle
        compare_data = 32'd10;
        next_cycle;
        mem_valid = 1'b1; ov_M = 1'b1; pc_M = 32'h8000_5000;
        next_cycle;
        clear_inputs;
        rst = 1'b1;
        @(negedge clk);
        check_value("rstfl_flush", {31'h0, flush}, 32'h0);
        check_value("rstfl_we", we, 32'h0);
        next_cycle;
        rst = 1'b0;
        Status_data = 32'h0000_8001;
        @(negedge clk);
        check_value("post_rst_flush", {31'h0, flush}, 32'h0);
        check_value("post_rst_redirect", {31'h0, redirect}, 32'h0);

        // Count restarted at 0: with TIMER_DIV=2 it equals 10 after 20 edges,
        // so the interrupt appears one edge later.
        repeat (20) next_cycle;
        @(negedge clk);
        check_value("timer_before", {24'h0, interrupt_enable}, 32'h00);
        next_cycle;
        @(negedge clk);
        check_value("timer_irq", {24'h0, interrupt_enable}, 32'h80);

        // Interrupt outranks a fetch address error
        next_cycle;
        mem_valid = 1'b1; fetch_adel_M = 1'b1; pc_M = 32'h8000_4000;
        @(negedge clk);
        check_value("int_code", {27'h0, Exception_code}, 32'h00);
        check_value("int_we", we, 32'h0000_7000);
        check_value("int_epc", epc, 32'h8000_4000);
        check_value("int_flush", {31'h0, flush}, 32'h1);
        next_cycle;
        clear_inputs;
        Status_data = 32'h0;
        compare_we = 1'b1;
        @(negedge clk);
        check_value("cmpwe_pending", {24'h0, interrupt_enable}, 32'h80);
        next_cycle;
        compare_we = 1'b0;
        @(negedge clk);
        check_value("cmpwe_clear", {24'h0, interrupt_enable}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
